// File: rtl/shading_unit.sv
// Shading stage: queues shaded-hit records, computes the clamped Lambert term
// N.L, applies the shadow flag and an ambient floor, scales the surface colour
// and hands the pixel colour plus coordinates to the framebuffer writer.
module shading_unit #(
  parameter int DATA_W  = 32,
  parameter int FW      = 16,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int DEPTH   = 4,
  parameter int AMBIENT = 16384
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     add_input,
  input  logic signed [DATA_W-1:0] in_nx,
  input  logic signed [DATA_W-1:0] in_ny,
  input  logic signed [DATA_W-1:0] in_nz,
  input  logic        [23:0]       in_color,
  input  logic                     in_shadow,
  input  logic        [X_W-1:0]    in_x,
  input  logic        [Y_W-1:0]    in_y,
  input  logic signed [DATA_W-1:0] light_x,
  input  logic signed [DATA_W-1:0] light_y,
  input  logic signed [DATA_W-1:0] light_z,
  input  logic                     output_fifo_full,
  output logic                     fifo_full,
  output logic                     valid,
  output logic        [23:0]       out_color,
  output logic        [X_W-1:0]    out_x,
  output logic        [Y_W-1:0]    out_y
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 2;

  localparam logic        [FW:0]      ONE   = {1'b1, {FW{1'b0}}};
  localparam logic signed [SUM_W-1:0] ONE_S = {{(SUM_W-FW-1){1'b0}}, 1'b1, {FW{1'b0}}};
  localparam logic        [FW+1:0]    AMB_W = (FW+2)'(AMBIENT);

  typedef enum logic [1:0] {IDLE, DOT, SCALE, DONE} state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] nx;
    logic signed [DATA_W-1:0] ny;
    logic signed [DATA_W-1:0] nz;
    logic        [23:0]       color;
    logic                     shadow;
    logic        [X_W-1:0]    x;
    logic        [Y_W-1:0]    y;
  } rec_t;

  // Arithmetic shift back to FW format, then clamp into [0, 1.0].
  function automatic logic [FW:0] clamp_dot(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> FW;
    if (sh[SUM_W-1])    return '0;
    else if (sh > ONE_S) return ONE;
    else                 return sh[FW:0];
  endfunction

  // Light intensity never exceeds 1.0.
  function automatic logic [FW:0] sat_lit(input logic [FW+1:0] s);
    if (s > {1'b0, ONE}) return ONE;
    else                 return s[FW:0];
  endfunction

  // One colour channel times intensity, truncated and saturated to 8 bits.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [FW:0] lit);
    logic [FW+8:0] prod;
    logic [8:0]    sh;
    prod = (FW+9)'(c) * (FW+9)'(lit);
    sh   = prod[FW+8:FW];
    if (sh > 9'd255) return 8'hFF;
    else             return sh[7:0];
  endfunction

  state_t                   state_q;
  rec_t                     mem_q [DEPTH];
  rec_t                     in_rec;
  rec_t                     work_q;
  logic        [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic        [CW-1:0]     count_q, count_d;
  logic                     fifo_full_q;
  logic                     push, pop;
  logic signed [DATA_W-1:0] lx_q, ly_q, lz_q;
  logic signed [PROD_W-1:0] prod_x, prod_y, prod_z;
  logic signed [SUM_W-1:0]  dot_sum;
  logic        [FW:0]       d_q;
  logic        [FW+1:0]     lit_sum;
  logic        [FW:0]       lit;
  logic                     valid_q;
  logic        [23:0]       out_color_q;
  logic        [X_W-1:0]    out_x_q;
  logic        [Y_W-1:0]    out_y_q;

  assign in_rec = '{nx: in_nx, ny: in_ny, nz: in_nz, color: in_color,
                    shadow: in_shadow, x: in_x, y: in_y};
  assign push   = add_input && !fifo_full_q;
  assign pop    = (state_q == IDLE) && (count_q != '0);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // FIFO control: pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_full_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      fifo_full_q <= (count_d == CW'(DEPTH));
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_rec;
  end

  // Dot product of the working normal with the light sampled at pop.
  always_comb begin
    prod_x  = PROD_W'($signed(work_q.nx)) * PROD_W'(lx_q);
    prod_y  = PROD_W'($signed(work_q.ny)) * PROD_W'(ly_q);
    prod_z  = PROD_W'($signed(work_q.nz)) * PROD_W'(lz_q);
    dot_sum = SUM_W'(prod_x) + SUM_W'(prod_y) + SUM_W'(prod_z);
    lit_sum = AMB_W + (work_q.shadow ? '0 : (FW+2)'(d_q));
    lit     = sat_lit(lit_sum);
  end

  // Working record, light snapshot and clamped Lambert term.
  always_ff @(posedge clk) begin
    if (pop) begin
      work_q <= mem_q[rd_ptr_q];
      lx_q   <= light_x;
      ly_q   <= light_y;
      lz_q   <= light_z;
    end
    if (state_q == DOT) d_q <= clamp_dot(dot_sum);
  end

  // Sequencer with registered outputs: pop, dot, scale, hand off.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      out_color_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (count_q != '0) state_q <= DOT;
        end
        DOT: begin
          state_q <= SCALE;
        end
        SCALE: begin
          out_color_q <= {scale_ch(work_q.color[23:16], lit),
                          scale_ch(work_q.color[15:8],  lit),
                          scale_ch(work_q.color[7:0],   lit)};
          out_x_q     <= work_q.x;
          out_y_q     <= work_q.y;
          state_q     <= DONE;
        end
        DONE: begin
          if (!output_fifo_full) begin
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo_full = fifo_full_q;
  assign valid     = valid_q;
  assign out_color = out_color_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_shading_unit.sv
// Directed testbench for shading_unit.
module tb_shading_unit;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               add_input = 1'b0;
  logic signed [31:0] in_nx = '0, in_ny = '0, in_nz = '0;
  logic        [23:0] in_color = '0;
  logic               in_shadow = 1'b0;
  logic        [9:0]  in_x = '0;
  logic        [8:0]  in_y = '0;
  logic signed [31:0] light_x = '0, light_y = 32'sd65536, light_z = '0;
  logic               output_fifo_full = 1'b0;
  logic               fifo_full;
  logic               valid;
  logic        [23:0] out_color;
  logic        [9:0]  out_x;
  logic        [8:0]  out_y;

  int checks = 0;
  int errors = 0;

  shading_unit #(
    .DATA_W(32), .FW(16), .X_W(10), .Y_W(9), .DEPTH(4), .AMBIENT(16384)
  ) dut (
    .clk(clk), .resetn(resetn), .add_input(add_input),
    .in_nx(in_nx), .in_ny(in_ny), .in_nz(in_nz),
    .in_color(in_color), .in_shadow(in_shadow), .in_x(in_x), .in_y(in_y),
    .light_x(light_x), .light_y(light_y), .light_z(light_z),
    .output_fifo_full(output_fifo_full), .fifo_full(fifo_full),
    .valid(valid), .out_color(out_color), .out_x(out_x), .out_y(out_y)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] colf(input int i);
    return {8'(20 * i + 1), 8'(i + 3), 8'(255 - i)};
  endfunction

  // Present one record for a single clock edge.
  task automatic push_rec(input logic signed [31:0] nx, input logic signed [31:0] ny,
                          input logic signed [31:0] nz, input logic [23:0] col,
                          input logic sh, input logic [9:0] x, input logic [8:0] y);
    in_nx = nx; in_ny = ny; in_nz = nz; in_color = col;
    in_shadow = sh; in_x = x; in_y = y;
    add_input = 1'b1;
    @(posedge clk); #1;
    add_input = 1'b0;
  endtask

  // Edges until valid is seen (-1 if it never comes).
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // One isolated record: latency, pulse width and data.
  task automatic run_one(input string name,
                         input logic signed [31:0] nx, input logic signed [31:0] ny,
                         input logic signed [31:0] nz, input logic [23:0] col, input logic sh,
                         input logic [9:0] x, input logic [8:0] y, input logic [23:0] exp_col);
    int lat;
    push_rec(nx, ny, nz, col, sh, x, y);
    wait_valid(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 4", name, lat);
    end
    checks++;
    if (out_color !== exp_col || out_x !== x || out_y !== y) begin
      errors++;
      $display("FAIL %s data: got color %h x %0d y %0d expected color %h x %0d y %0d",
               name, out_color, out_x, out_y, exp_col, x, y);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: valid got %b expected 0 one cycle later", name, valid);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || fifo_full !== 1'b0 || out_color !== 24'h0 ||
        out_x !== 10'd0 || out_y !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b full %b color %h x %0d y %0d expected all 0",
               valid, fifo_full, out_color, out_x, out_y);
    end
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_lambert;
    light_x = 0; light_y = 32'sd65536; light_z = 0;
    run_one("full_light", 0, 32'sd65536, 0, {8'd200, 8'd100, 8'd50}, 1'b0, 10'd5, 9'd7,
            {8'd200, 8'd100, 8'd50});
    run_one("shadowed", 0, 32'sd65536, 0, {8'd200, 8'd100, 8'd50}, 1'b1, 10'd6, 9'd8,
            {8'd50, 8'd25, 8'd12});
    run_one("half_normal", 0, 32'sd32768, 0, {8'd200, 8'd100, 8'd50}, 1'b0, 10'd7, 9'd9,
            {8'd150, 8'd75, 8'd37});
    run_one("back_facing", 0, -32'sd65536, 0, {8'd200, 8'd100, 8'd50}, 1'b0, 10'd8, 9'd10,
            {8'd50, 8'd25, 8'd12});
    light_x = 32'sd32768; light_y = 32'sd32768; light_z = 0;
    run_one("xy_mix", 32'sd32768, 32'sd32768, 0, {8'd200, 8'd100, 8'd50}, 1'b0, 10'd9, 9'd11,
            {8'd150, 8'd75, 8'd37});
    light_x = 0; light_y = 0; light_z = 32'sd65536;
    run_one("z_quarter", 0, 0, 32'sd16384, {8'd200, 8'd100, 8'd50}, 1'b0, 10'd10, 9'd12,
            {8'd100, 8'd50, 8'd25});
    light_x = 0; light_y = 32'sd65536; light_z = 0;
  endtask

  task automatic test_full_stall;
    logic [9:0] got_x [8];
    int         got_c [8];
    int         n;
    output_fifo_full = 1'b1;
    push_rec(0, 32'sd65536, 0, colf(0), 1'b0, 10'd100, 9'd1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_valid: got %b expected 0", valid);
    end
    for (int i = 1; i <= 4; i++)
      push_rec(0, 32'sd65536, 0, colf(i), 1'b0, 10'(100 + i), 9'd1);
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL full_after_fill: got %b expected 1", fifo_full);
    end
    push_rec(0, 32'sd65536, 0, colf(9), 1'b0, 10'd199, 9'd1);
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL full_after_drop: got %b expected 1", fifo_full);
    end
    output_fifo_full = 1'b0;
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        if (n < 8) begin
          got_x[n] = out_x;
          got_c[n] = c;
        end
        n++;
      end
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL drain_count: got %0d pulses expected 5", n);
    end
    for (int i = 0; i < 5 && i < n; i++) begin
      checks++;
      if (got_x[i] !== 10'(100 + i) || got_c[i] !== 1 + 4 * i) begin
        errors++;
        $display("FAIL drain_%0d: got x %0d at cycle %0d expected x %0d at cycle %0d",
                 i, got_x[i], got_c[i], 100 + i, 1 + 4 * i);
      end
    end
  endtask

  task automatic test_wrap_order;
    logic [9:0]  got_x [12];
    logic [23:0] got_col [12];
    int          n;
    n = 0;
    fork
      begin
        for (int pi = 0; pi < 9; pi++) begin
          push_rec(0, 32'sd65536, 0, colf(pi), 1'b0, 10'(200 + pi), 9'(pi));
          repeat (2) @(posedge clk);
          #1;
        end
      end
      begin
        for (int ci = 0; ci < 120; ci++) begin
          @(posedge clk); #1;
          if (valid) begin
            if (n < 12) begin
              got_x[n]   = out_x;
              got_col[n] = out_color;
            end
            n++;
          end
        end
      end
    join
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL wrap_count: got %0d pulses expected 9", n);
    end
    for (int i = 0; i < 9 && i < n; i++) begin
      checks++;
      if (got_x[i] !== 10'(200 + i) || got_col[i] !== colf(i)) begin
        errors++;
        $display("FAIL wrap_%0d: got x %0d color %h expected x %0d color %h",
                 i, got_x[i], got_col[i], 200 + i, colf(i));
      end
    end
  endtask

  task automatic test_reset_midflight;
    int seen;
    push_rec(0, 32'sd65536, 0, colf(1), 1'b0, 10'd300, 9'd3);
    push_rec(0, 32'sd65536, 0, colf(2), 1'b0, 10'd301, 9'd3);
    push_rec(0, 32'sd65536, 0, colf(3), 1'b0, 10'd302, 9'd3);
    resetn = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || fifo_full !== 1'b0 || out_color !== 24'h0 ||
        out_x !== 10'd0 || out_y !== 9'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid %b full %b color %h x %0d y %0d expected all 0",
               valid, fifo_full, out_color, out_x, out_y);
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d pulses expected 0", seen);
    end
    run_one("after_reset", 0, 32'sd65536, 0, {8'd200, 8'd100, 8'd50}, 1'b1, 10'd400, 9'd4,
            {8'd50, 8'd25, 8'd12});
  endtask

  initial begin
    test_reset();
    test_lambert();
    test_full_stall();
    test_wrap_order();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
